// File: rtl/sc_fifo_pkg.sv
// rtl/sc_fifo_pkg.sv - shared types and helpers for the single-clock FIFO
package sc_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int fifo_depth(input int addr_size);
    return 1 << addr_size;
  endfunction

endpackage

// File: rtl/sc_fifo_ram.sv
// rtl/sc_fifo_ram.sv - FIFO storage, synchronous write and combinational read
module sc_fifo_ram
  import sc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_SIZE-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_SIZE-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [fifo_depth(ADDR_SIZE)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sc_fifo.sv
// rtl/sc_fifo.sv - single-clock FIFO with FWFT option, occupancy count and thresholds
module sc_fifo
  import sc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_SIZE  = 8,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  w_en,
  input  logic                  r_en,
  input  logic [ADDR_SIZE:0]    af_thresh,
  input  logic [ADDR_SIZE:0]    ae_thresh,
  output logic [DATA_WIDTH-1:0] out,
  output logic [ADDR_SIZE:0]    count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                 DEPTH     = fifo_depth(ADDR_SIZE);
  localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE + 1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] ONE       = (ADDR_SIZE + 1)'(1);
  localparam fifo_mode_e         MODE      = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  logic [ADDR_SIZE:0]    w_ptr;
  logic [ADDR_SIZE:0]    r_ptr;
  logic [ADDR_SIZE:0]    count_q;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rdata;

  // Flags come straight from the count register so they are unambiguous at pointer wrap.
  assign count        = count_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DEPTH_CNT);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);

  assign wr_ok = w_en & ~full  & ~clr;
  assign rd_ok = r_en & ~empty & ~clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        w_ptr <= w_ptr + ONE;
      end
      if (rd_ok) begin
        r_ptr <= r_ptr + ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_q <= count_q + ONE;
        2'b01:   count_q <= count_q - ONE;
        default: count_q <= count_q;
      endcase
      if (w_en && full) begin
        overflow <= 1'b1;
      end
      if (r_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  sc_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (w_ptr[ADDR_SIZE-1:0]),
    .wdata (w_data),
    .raddr (r_ptr[ADDR_SIZE-1:0]),
    .rdata (rdata)
  );

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      assign out = rdata;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] out_q;

      // Loaded only on an accepted read, so flush and rejected reads leave it untouched.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          out_q <= '0;
        end else if (rd_ok) begin
          out_q <= rdata;
        end
      end

      assign out = out_q;
    end
  endgenerate

endmodule

// File: tb/tb_sc_fifo.sv
// tb/tb_sc_fifo.sv - scoreboard bench for sc_fifo in standard and FWFT modes
module tb_sc_fifo;

  logic        clk;
  logic        rst;

  logic        s_clr, s_w_en, s_r_en;
  logic [15:0] s_w_data, s_out;
  logic [3:0]  s_af, s_ae, s_count;
  logic        s_empty, s_full, s_afl, s_aem, s_ovf, s_unf;

  logic        f_clr, f_w_en, f_r_en;
  logic [15:0] f_w_data, f_out;
  logic [3:0]  f_af, f_ae, f_count;
  logic        f_empty, f_full, f_afl, f_aem, f_ovf, f_unf;

  int          n_pass = 0;
  int          n_total = 0;
  int          s_issued = 0;
  int          s_seen = 0;
  logic [15:0] mq[$];
  logic [15:0] s_exp_q[$];
  logic [15:0] fq[$];
  bit          m_ovf = 0;
  bit          m_unf = 0;

  sc_fifo #(.DATA_WIDTH(16), .ADDR_SIZE(3), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .clr(s_clr), .w_data(s_w_data), .w_en(s_w_en), .r_en(s_r_en),
    .af_thresh(s_af), .ae_thresh(s_ae), .out(s_out), .count(s_count), .empty(s_empty),
    .full(s_full), .almost_full(s_afl), .almost_empty(s_aem), .overflow(s_ovf), .underflow(s_unf)
  );

  sc_fifo #(.DATA_WIDTH(16), .ADDR_SIZE(3), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .clr(f_clr), .w_data(f_w_data), .w_en(f_w_en), .r_en(f_r_en),
    .af_thresh(f_af), .ae_thresh(f_ae), .out(f_out), .count(f_count), .empty(f_empty),
    .full(f_full), .almost_full(f_afl), .almost_empty(f_aem), .overflow(f_ovf), .underflow(f_unf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Standard-mode monitor pops one expected word per accepted read; FWFT monitor checks the head.
  always @(negedge clk) begin
    if (s_seen < s_issued) begin
      s_seen++;
      if (s_exp_q.size() == 0) begin
        n_total++;
        $display("FAIL std_rd_data: got 0x%0h with no expected word queued", s_out);
      end else begin
        chk("std_rd_data", s_out, s_exp_q.pop_front());
      end
    end
    if (fq.size() > 0) chk("fwft_head", f_out, fq[0]);
  end

  task automatic s_step(input logic w, input logic [15:0] d, input logic r);
    bit wr_acc, rd_acc;
    wr_acc = w && (mq.size() < 8);
    rd_acc = r && (mq.size() > 0);
    if (w && !wr_acc) m_ovf = 1;
    if (r && !rd_acc) m_unf = 1;
    if (rd_acc) s_exp_q.push_back(mq.pop_front());
    if (wr_acc) mq.push_back(d);
    s_w_en = w; s_w_data = d; s_r_en = r;
    @(posedge clk);
    #1;
    s_w_en = 0; s_r_en = 0;
    if (rd_acc) s_issued++;
  endtask

  task automatic s_clear(input logic w, input logic r);
    s_clr = 1; s_w_en = w; s_r_en = r; s_w_data = 16'hDEAD;
    @(posedge clk);
    #1;
    s_clr = 0; s_w_en = 0; s_r_en = 0;
    mq.delete(); m_ovf = 0; m_unf = 0;
  endtask

  task automatic s_state(input string tag);
    chk({tag, "_count"}, s_count, mq.size());
    chk({tag, "_empty"}, s_empty, mq.size() == 0);
    chk({tag, "_full"},  s_full,  mq.size() == 8);
    chk({tag, "_ovf"},   s_ovf,   m_ovf);
    chk({tag, "_unf"},   s_unf,   m_unf);
  endtask

  task automatic f_step(input logic w, input logic [15:0] d, input logic r);
    bit wr_acc, rd_acc;
    wr_acc = w && (fq.size() < 8);
    rd_acc = r && (fq.size() > 0);
    f_w_en = w; f_w_data = d; f_r_en = r;
    @(posedge clk);
    if (rd_acc) void'(fq.pop_front());
    if (wr_acc) fq.push_back(d);
    #1;
    f_w_en = 0; f_r_en = 0;
  endtask

  initial begin
    rst = 0;
    s_clr = 0; s_w_en = 0; s_r_en = 0; s_w_data = 0; s_af = 4'd6; s_ae = 4'd2;
    f_clr = 0; f_w_en = 0; f_r_en = 0; f_w_data = 0; f_af = 4'd6; f_ae = 4'd2;
    #2;
    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_aem", s_aem, 1);
    chk("rst_afl", s_afl, 0);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_out", s_out, 0);
    @(negedge clk);
    rst = 1;

    // Fill with threshold tracking (af=6, ae=2)
    for (int i = 1; i <= 8; i++) begin
      s_step(1, 16'(i), 0);
      chk("fill_aem", s_aem, (i <= 2));
      chk("fill_afl", s_afl, (i >= 6));
      if (i == 7) begin
        s_af = 4'd8;
        #1;
        chk("af_change_drop", s_afl, 0);
        s_af = 4'd6;
      end
    end
    chk("fill_full", s_full, 1);
    chk("fill_count", s_count, 8);
    s_step(1, 16'h0009, 0);
    chk("ovf_set", s_ovf, 1);
    chk("ovf_count", s_count, 8);
    s_state("ovf");

    // Drain three, then flush with count=5 and overflow set; same-cycle ops ignored
    for (int i = 0; i < 3; i++) s_step(0, 0, 1);
    chk("pre_clr_count", s_count, 5);
    chk("pre_clr_ovf", s_ovf, 1);
    s_clear(1, 1);
    chk("clr_count", s_count, 0);
    chk("clr_empty", s_empty, 1);
    chk("clr_ovf", s_ovf, 0);
    chk("clr_out_hold", s_out, 16'h0003);

    // Simultaneous read/write at count=4
    for (int i = 0; i < 4; i++) s_step(1, 16'h0010 + 16'(i), 0);
    for (int i = 0; i < 10; i++) begin
      s_step(1, 16'h0020 + 16'(i), 1);
      chk("simul_count", s_count, 4);
    end
    for (int i = 0; i < 4; i++) s_step(0, 0, 1);
    s_state("simul_drain");
    s_step(1, 16'h0077, 1);
    chk("empty_rw_count", s_count, 1);
    chk("empty_rw_unf", s_unf, 1);
    s_step(0, 0, 1);
    s_state("unf_drain");
    s_clear(0, 0);
    s_state("clr2");

    // Wrap: 20 pairs with two words in flight, then fill to full
    s_step(1, 16'h0100, 0);
    s_step(1, 16'h0101, 0);
    for (int i = 0; i < 20; i++) begin
      s_step(1, 16'h0102 + 16'(i), 1);
      chk("wrap_count_le3", (s_count <= 4'd3), 1);
    end
    s_step(0, 0, 1);
    s_step(0, 0, 1);
    for (int i = 0; i < 8; i++) s_step(1, 16'h0200 + 16'(i), 0);
    chk("wrap_full", s_full, 1);
    chk("wrap_full_count", s_count, 8);
    for (int i = 0; i < 8; i++) s_step(0, 0, 1);
    s_state("wrap_drain");

    // FWFT mode
    chk("f_init_empty", f_empty, 1);
    f_step(1, 16'hA5A5, 0);
    chk("f_empty_fall", f_empty, 0);
    chk("f_first_out", f_out, 16'hA5A5);
    f_step(1, 16'h1111, 0);
    f_step(1, 16'h2222, 0);
    chk("f_head_hold", f_out, 16'hA5A5);
    chk("f_count3", f_count, 3);
    f_step(0, 0, 1);
    chk("f_pop1", f_out, 16'h1111);
    f_step(0, 0, 1);
    chk("f_pop2", f_out, 16'h2222);
    f_step(0, 0, 1);
    chk("f_pop3_empty", f_empty, 1);
    chk("f_pop3_count", f_count, 0);

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 3; i++) s_step(1, 16'h0300 + 16'(i), 0);
    s_w_en = 1; s_w_data = 16'h5555;
    #2;
    rst = 0;
    #1;
    chk("arst_count", s_count, 0);
    chk("arst_empty", s_empty, 1);
    chk("arst_full", s_full, 0);
    chk("arst_aem", s_aem, 1);
    chk("arst_afl", s_afl, 0);
    chk("arst_out", s_out, 0);
    chk("arst_f_empty", f_empty, 1);
    s_af = 4'd0;
    #1;
    chk("arst_afl_thr0", s_afl, 1);
    s_af = 4'd6;
    s_w_en = 0;
    mq.delete(); fq.delete(); m_ovf = 0; m_unf = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    s_step(1, 16'hBEEF, 0);
    s_step(0, 0, 1);
    s_state("post_rst");

    repeat (3) @(negedge clk);
    chk("rd_words_seen", s_seen, s_issued);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sc_fifo.md
Name: sc_fifo

Overview:
Single-clock, parametrised FIFO. It is the next generation of the team's FIFO family, for use inside one clock domain where a gray-coded dual-clock FIFO is overkill. Over the dual-clock version it adds:
- a first-word-fall-through (FWFT) mode
- an exact occupancy count
- runtime-programmable almost-full and almost-empty thresholds
- a synchronous flush
- sticky overflow and underflow error flags

Parameters:
DATA_WIDTH, 16, word width in bits
ADDR_SIZE, 8, address bits; DEPTH = 2**ADDR_SIZE entries
FWFT, 0, 0 = standard read (data 1 cycle after r_en); 1 = head word presented on out while !empty

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets)
clr  in  1  synchronous flush, active-high
w_data  in  DATA_WIDTH  write data
w_en  in  1  write request
r_en  in  1  read request (in FWFT mode: acknowledge/pop)
af_thresh  in  ADDR_SIZE+1  almost_full threshold
ae_thresh  in  ADDR_SIZE+1  almost_empty threshold
out  out  DATA_WIDTH  read data
count  out  ADDR_SIZE+1  occupancy, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Pointers and count:
  - w_ptr and r_ptr are ADDR_SIZE+1-bit binary; the MSB is the wrap bit.
  - Memory address is the low ADDR_SIZE bits.
  - count is a register, updated by +1, -1 or 0 per cycle. It must equal w_ptr - r_ptr (mod 2**(ADDR_SIZE+1)).
- Accept rules (evaluated on flags before the edge):
  - wr_ok = w_en & ~full
  - rd_ok = r_en & ~empty
  - Both ok: both pointers advance; count unchanged.
  - Empty with w_en & r_en: the write is accepted, the read is rejected, underflow sets.
  - Full with w_en & r_en: the read is accepted, the write is rejected, overflow sets.
  - Rejected operations change no pointer, memory word or out.
- Flags:
  - empty, full, almost_full and almost_empty are combinational from the count register and the threshold ports.
  - Threshold changes take effect in the same cycle.
- Standard mode (FWFT=0):
  - out is a register loaded with mem[r_addr] on the edge where rd_ok. Read latency is 1 cycle.
  - out holds its value otherwise.
- FWFT mode (FWFT=1):
  - out = mem[r_addr] (combinational read) whenever !empty.
  - empty falls 1 cycle after the first accepted write into an empty FIFO.
  - On rd_ok, out shows the next word in the following cycle, so back-to-back pops run at 1 word/cycle.
  - out is don't-care while empty.
- Sticky flags: overflow and underflow set on the edge of the offending request and stay set until clr or reset.
- clr (synchronous):
  - Pointers and count go to 0; overflow and underflow clear.
  - out holds its value (FWFT=0).
  - Same-cycle w_en and r_en are ignored.
  - Memory contents are not cleared.
- Reset (rst=0, asynchronous, at any time including mid-burst):
  - Pointers and count go to 0; out goes to 0; overflow and underflow go to 0.
  - Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=(af_thresh==0).
- Wrap-around: pointers roll over modulo 2**(ADDR_SIZE+1). full and empty derive from count, so there is no ambiguity at wrap.
- Threshold values above DEPTH are legal: almost_full never asserts; almost_empty is always 1.

Decomposition:
- Package sc_fifo_pkg holds:
  - localparam-style function fifo_depth(addr_size)
  - typedef enum {FIFO_STD, FIFO_FWFT} fifo_mode_e, for documentation and TB use; the FWFT parameter maps to it
- One sub-module, sc_fifo_ram:
  - DEPTH x DATA_WIDTH array
  - synchronous write on clk when we
  - combinational read at raddr
  - no reset

Test Plan:
All scenarios use DATA_WIDTH=16, ADDR_SIZE=3 (DEPTH=8).
- Fill/drain, FWFT=0: write 0x0001..0x0008 → full=1, count=8 after the 8th edge. A 9th write sets overflow=1 and count stays 8. Reading 8 words returns 0x0001..0x0008, each 1 cycle after its r_en; then empty=1.
- Simultaneous ops: count=4, w_en=r_en=1 for 10 cycles → count stays 4 and data order is preserved. When empty, w_en=r_en=1 → count=1, underflow=1.
- FWFT=1: write 0xA5A5 into an empty FIFO → empty=0 and out=0xA5A5 the next cycle. Write 0x1111 and 0x2222, then pop 3 times on consecutive cycles → out shows 0xA5A5, 0x1111, 0x2222 with no gap; empty=1 after the 3rd pop.
- Thresholds: af_thresh=6, ae_thresh=2; write 7 words one at a time:
  - almost_empty=1 for count 0..2, 0 from count 3 on.
  - almost_full rises at count 6.
  - Changing af_thresh to 8 drops almost_full in the same cycle.
- Wrap: 20 write/read pairs with the FIFO never exceeding 3 entries → all data matches and count never exceeds 3. Then fill to 8 → full=1, so full is correct across pointer wrap.
- clr/reset: count=5 and overflow=1, pulse clr → next cycle count=0, empty=1, overflow=0. Assert rst=0 asynchronously mid-write-burst → outputs reset immediately, independent of clk. After release, the first write/read round-trips correctly.
